// File: rtl/median_window_gen.sv
// median_window_gen: builds 3x3 pixel windows from a raster stream for a
// downstream compare-swap median sort network. Two line buffers hold the
// previous two rows. A 3x3 shift window moves one column per accepted pixel.
// Windows are emitted only for interior pixels, through a single output stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// WAIT_SOF | idle between frames; non-sof pixels are dropped
// RUN      | inside a frame; every accepted pixel advances col/row
module median_window_gen #(
  parameter int DATA_SIZE  = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_SIZE-1:0]   pixIn,
  input  logic                   pixValid,
  input  logic                   pixSof,
  output logic                   pixReady,
  output logic [9*DATA_SIZE-1:0] winOut,
  output logic                   winValid,
  input  logic                   winReady
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_FIRST = RW'(2);

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [8:0][DATA_SIZE-1:0] win_q, win_d;
  logic [8:0][DATA_SIZE-1:0] win_out_q, win_out_d;
  logic win_valid_q, win_valid_d;

  // Line buffers are plain storage with no reset. The row>=2 gate keeps stale
  // contents out of every emitted window.
  logic [DATA_SIZE-1:0] line1_q [IMG_WIDTH];
  logic [DATA_SIZE-1:0] line2_q [IMG_WIDTH];

  logic                 accept;
  logic                 pix_take;
  logic                 emit;
  logic [CW-1:0]        cur_col;
  logic [RW-1:0]        cur_row;
  logic [DATA_SIZE-1:0] line1_rd;
  logic [DATA_SIZE-1:0] line2_rd;

  assign pixReady = !win_valid_q || winReady;
  assign winOut   = win_out_q;
  assign winValid = win_valid_q;

  // Decide whether this beat is taken and at which position it lands. A sof
  // always re-anchors the pixel to col 0, row 0.
  always_comb begin
    accept   = pixValid && pixReady;
    pix_take = accept && (pixSof || (state_q == RUN));
    cur_col  = pixSof ? '0 : col_q;
    cur_row  = pixSof ? '0 : row_q;
    line1_rd = line1_q[cur_col];
    line2_rd = line2_q[cur_col];
    emit     = pix_take && (cur_col >= COL_FIRST) && (cur_row >= ROW_FIRST);
  end

  // Next-state logic: frame position and FSM, window shift, and output stage.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    win_out_d   = win_out_q;
    win_valid_d = win_valid_q && !winReady;

    if (pix_take) begin
      // Oldest column drops out; the new column is {row r-2, row r-1, row r}.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[2] = line2_rd;
      win_d[5] = line1_rd;
      win_d[8] = pixIn;

      state_d = RUN;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d   = '0;
          state_d = WAIT_SOF;
        end else begin
          row_d = cur_row + 1'b1;
        end
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end

      if (emit) begin
        win_out_d   = win_d;
        win_valid_d = 1'b1;
      end
    end
  end

  // Control and window registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_SOF;
      col_q       <= '0;
      row_q       <= '0;
      win_q       <= '0;
      win_out_q   <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_q       <= win_d;
      win_out_q   <= win_out_d;
      win_valid_q <= win_valid_d;
    end
  end

  // Line buffer update: row r enters line1 and the old row r-1 moves to line2.
  always_ff @(posedge clk) begin
    if (pix_take) begin
      line1_q[cur_col] <= pixIn;
      line2_q[cur_col] <= line1_rd;
    end
  end

endmodule

// File: tb/tb_median_window_gen.sv
// Bench for median_window_gen on a 4x4 image. A frame-level reference keeps the
// current image in a 2D array and cuts each expected window from it directly.
module tb_median_window_gen;

  localparam int D = 8;
  localparam int W = 4;
  localparam int H = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [D-1:0]   pixIn;
  logic           pixValid;
  logic           pixSof;
  logic           pixReady;
  logic [9*D-1:0] winOut;
  logic           winValid;
  logic           winReady;

  always #5 clk = ~clk;

  median_window_gen #(
    .DATA_SIZE (D),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pixIn   (pixIn),
    .pixValid(pixValid),
    .pixSof  (pixSof),
    .pixReady(pixReady),
    .winOut  (winOut),
    .winValid(winValid),
    .winReady(winReady)
  );

  localparam logic [9*D-1:0] WIN_FIRST =
    {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [9*D-1:0] WIN_LAST =
    {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic           m_valid;
  logic [9*D-1:0] m_out;
  bit             m_inframe;
  int             m_row;
  int             m_col;
  logic [D-1:0]   img [H][W];

  int             xfers;
  int             stalls;
  logic [9*D-1:0] first_win;
  logic [9*D-1:0] last_win;

  task automatic chk(input string tag, input logic [9*D-1:0] obs, input logic [9*D-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid   = 1'b0;
    m_out     = '0;
    m_inframe = 1'b0;
    m_row     = 0;
    m_col     = 0;
  endtask

  // One clock: drive, check DUT against the model, advance the model, clock.
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [D-1:0] p, input logic wr, output bit acc);
    logic m_ready;
    logic nv;
    rst      = r;
    pixValid = v;
    pixSof   = s;
    pixIn    = p;
    winReady = wr;
    #1;
    m_ready = !m_valid || wr;
    chk("pixReady", {71'd0, pixReady}, {71'd0, m_ready});
    chk("winValid", {71'd0, winValid}, {71'd0, m_valid});
    chk("winOut", winOut, m_out);
    if (winValid === 1'b1 && wr) begin
      if (xfers == 0) first_win = winOut;
      last_win = winOut;
      xfers++;
    end
    acc = v && m_ready && !r;
    if (r) begin
      model_reset();
    end else begin
      nv = m_valid && !wr;
      if (acc && (s || m_inframe)) begin
        if (s) begin
          m_row = 0;
          m_col = 0;
        end
        img[m_row][m_col] = p;
        if (m_row >= 2 && m_col >= 2) begin
          for (int k = 0; k < 9; k++)
            m_out[D*k +: D] = img[m_row-2+k/3][m_col-2+k%3];
          nv = 1'b1;
        end
        m_inframe = 1'b1;
        if (m_col == W-1) begin
          m_col = 0;
          if (m_row == H-1) begin
            m_row     = 0;
            m_inframe = 1'b0;
          end else begin
            m_row++;
          end
        end else begin
          m_col++;
        end
      end
      m_valid = nv;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pix(input logic s, input logic [D-1:0] p, input logic wr);
    bit acc;
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, s, p, wr, acc);
      tries++;
    end while (!acc && tries < 20);
    chk("accepted", {71'd0, acc}, 72'd1);
    stalls += tries - 1;
  endtask

  task automatic send_frame(input int first, input int last, input bit sof_first);
    for (int i = first; i <= last; i++)
      send_pix(sof_first && (i == first), D'(i), 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0, acc);
    xfers  = 0;
    stalls = 0;
  endtask

  task automatic check_frame(input int n);
    chk("win_count", 72'(n), 72'(xfers));
    chk("first_win", first_win, WIN_FIRST);
    chk("last_win", last_win, WIN_LAST);
  endtask

  initial begin
    bit acc;
    rst      = 1'b1;
    pixValid = 1'b0;
    pixSof   = 1'b0;
    pixIn    = '0;
    winReady = 1'b0;
    xfers    = 0;
    stalls   = 0;
    first_win = '0;
    last_win  = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // reset state and a clean full frame
    do_reset();
    chk("rst_pixReady", {71'd0, pixReady}, 72'd1);
    chk("rst_winValid", {71'd0, winValid}, 72'd0);
    chk("rst_winOut", winOut, 72'd0);
    send_frame(0, 15, 1'b1);
    idle(3);
    check_frame(4);

    // leading non-sof pixels are discarded
    do_reset();
    for (int i = 0; i < 5; i++) send_pix(1'b0, D'(i), 1'b1);
    send_frame(0, 15, 1'b1);
    idle(3);
    check_frame(4);

    // backpressure on the first window
    do_reset();
    send_frame(0, 10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, D'(11), 1'b0, acc);
      chk("hold_acc", {71'd0, acc}, 72'd0);
      chk("hold_win", winOut, WIN_FIRST);
      chk("hold_ready", {71'd0, pixReady}, 72'd0);
    end
    send_frame(11, 15, 1'b0);
    idle(3);
    check_frame(4);

    // sof restart at pixel 6
    do_reset();
    send_frame(0, 5, 1'b1);
    send_frame(0, 15, 1'b1);
    idle(3);
    check_frame(4);

    // reset while a window is pending
    do_reset();
    send_frame(0, 10, 1'b1);
    step(1'b1, 1'b1, 1'b0, D'(11), 1'b0, acc);
    chk("rst_drop", {71'd0, winValid}, 72'd0);
    xfers = 0;
    for (int i = 12; i < 16; i++) send_pix(1'b0, D'(i), 1'b1);
    idle(2);
    chk("no_win_after_rst", 72'(xfers), 72'd0);
    send_frame(0, 15, 1'b1);
    idle(3);
    check_frame(4);

    // back-to-back frames with no gaps
    do_reset();
    send_frame(0, 15, 1'b1);
    send_frame(0, 15, 1'b1);
    idle(3);
    check_frame(8);
    chk("b2b_stalls", 72'(stalls), 72'd0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0),
           D'($urandom),
           ($urandom_range(0, 3) != 0),
           acc);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
